stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MIN_MAX, default 99: highest minute value (BCD-representable, 1..99).
REQ-002 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_startstop  input  1  one-cycle pulse: toggle run/pause.
REQ-005 cmd_lap  input  1  one-cycle pulse: freeze/release display.
REQ-006 cmd_clear  input  1  one-cycle pulse: zero the time when paused or full.
REQ-007 ms_tick  input  1  one-cycle pulse per millisecond from the ms pulse generator.
REQ-008 run_en  output  1  high while the ms pulse generator must run.
REQ-009 disp_min  output  8  two BCD digits, minutes.
REQ-010 disp_sec  output  8  two BCD digits, seconds 00..59.
REQ-011 disp_ms  output  12  three BCD digits, milliseconds 000..999.
REQ-012 lap_active  output  1  high while display is frozen.
REQ-013 full  output  1  high when time saturated at MIN_MAX:59.999.

Function
REQ-014 FSM states SHALL be IDLE, RUN, LAP, PAUSE, FULL.
REQ-015 Simultaneous commands SHALL be prioritised clear > startstop > lap; lower-priority commands in the same cycle are dropped.
REQ-016 IDLE: startstop -> RUN; clear and lap ignored.
REQ-017 RUN: startstop -> PAUSE; lap -> LAP with display capture of the live count in the same edge; clear ignored.
REQ-018 LAP: lap -> RUN (display follows live count next cycle); startstop -> PAUSE with display released to live count; clear ignored.
REQ-019 PAUSE: startstop -> RUN; clear -> IDLE with all counters zeroed on the same edge; lap ignored.
REQ-020 FULL: clear -> IDLE with counters zeroed; startstop and lap ignored.
REQ-021 Live count SHALL increment by 1 ms on each clk edge where ms_tick=1 and registered state is RUN or LAP, including the edge on which that state is exited.
REQ-022 Carry chain: ms 999->000 carries into sec; sec 59->00 carries into min; all in one cycle.
REQ-023 A tick while live count equals MIN_MAX:59.999 SHALL hold the count and move to FULL (no wrap).
REQ-024 run_en SHALL be a registered decode, 1 exactly when state is RUN or LAP.
REQ-025 disp_* SHALL show the captured lap value in LAP, live count otherwise; outputs registered, one-cycle latency from counter update.
REQ-026 lap_active=1 only in LAP; full=1 only in FULL.
REQ-027 ms_tick outside RUN/LAP SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE, all counters and lap capture to zero, run_en=0, lap_active=0, full=0, disp_*=0, immediately and independent of clk.
REQ-029 Reset asserted mid-RUN SHALL discard the count; after release the block waits in IDLE for startstop.

Structure
REQ-030 State encoding, digit maxima (9, 5) and width constants SHALL live in shared package stopwatch_pkg.
REQ-031 One sub-module, bcd_digit_cnt (4-bit digit, parameter max value, inc/carry_in, carry_out, clear), SHALL be instantiated seven times for the chain.

Verification
REQ-032 Reset, startstop, 1234 ms_ticks -> run_en=1, display 00:01.234.
REQ-033 Count 00:59.999, one tick -> 01:00.000 in one cycle, no intermediate value visible.
REQ-034 RUN at 00:02.000, lap, 500 ticks -> display 00:02.000, lap_active=1; lap -> display 00:02.500.
REQ-035 startstop and clear in same cycle while PAUSE -> IDLE, display 00:00.000, run_en=0.
REQ-036 MIN_MAX=1, run to 01:59.999, one tick -> full=1, run_en=0, count held; clear -> IDLE, zero.
REQ-037 rst asserted between clk edges in RUN -> all outputs zero before next edge; ticks ignored until startstop.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: state encoding,
// command priority decode, BCD digit limits and display field widths.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_LAP   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_FULL  = 3'd4
   } sw_state_t;

   typedef enum logic [1:0] {
      CMD_NONE      = 2'd0,
      CMD_CLEAR     = 2'd1,
      CMD_STARTSTOP = 2'd2,
      CMD_LAP       = 2'd3
   } sw_cmd_t;

   localparam int DIGIT_W = 4;
   localparam int MIN_W   = 8;
   localparam int SEC_W   = 8;
   localparam int MS_W    = 12;

   localparam logic [DIGIT_W-1:0] DEC_MAX      = 4'd9;
   localparam logic [DIGIT_W-1:0] TENS_SEC_MAX = 4'd5;

   typedef struct packed {
      logic [MIN_W-1:0] min;
      logic [SEC_W-1:0] sec;
      logic [MS_W-1:0]  ms;
   } sw_time_t;

   // Only one command acts per cycle: clear beats startstop beats lap.
   function automatic sw_cmd_t pick_cmd(input logic clear, input logic startstop, input logic lap);
      sw_cmd_t c;
      if (clear) begin
         c = CMD_CLEAR;
      end else if (startstop) begin
         c = CMD_STARTSTOP;
      end else if (lap) begin
         c = CMD_LAP;
      end else begin
         c = CMD_NONE;
      end
      return c;
   endfunction

   // Binary 0..99 to two packed BCD digits (used for the minute limit).
   function automatic logic [7:0] to_bcd2(input int unsigned v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'((v / 32'd10) % 32'd10);
      ones = 4'(v % 32'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Command/tick inputs and display/status outputs of the stopwatch controller.
// master drives commands and ticks; slave is the controller itself.
interface stopwatch_if;
   import stopwatch_pkg::*;

   logic             cmd_startstop;
   logic             cmd_lap;
   logic             cmd_clear;
   logic             ms_tick;
   logic             run_en;
   logic [MIN_W-1:0] disp_min;
   logic [SEC_W-1:0] disp_sec;
   logic [MS_W-1:0]  disp_ms;
   logic             lap_active;
   logic             full;

   modport master (
      output cmd_startstop, cmd_lap, cmd_clear, ms_tick,
      input  run_en, disp_min, disp_sec, disp_ms, lap_active, full
   );

   modport slave (
      input  cmd_startstop, cmd_lap, cmd_clear, ms_tick,
      output run_en, disp_min, disp_sec, disp_ms, lap_active, full
   );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// One BCD digit of the time counter. Wraps to zero after MAX_VAL and reports
// the wrap as carry_out in the same cycle so the whole chain ripples at once.
module bcd_digit_cnt
   import stopwatch_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX_VAL = DEC_MAX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               carry_in,
   output logic [DIGIT_W-1:0] value,
   output logic               carry_out
);

   logic at_max;

   assign at_max    = (value == MAX_VAL);
   assign carry_out = carry_in & at_max;

   // Digit register: clear wins over increment, wrap to zero past MAX_VAL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= 4'd0;
      end else if (clear) begin
         value <= 4'd0;
      end else if (carry_in) begin
         value <= at_max ? 4'd0 : value + 4'd1;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM over a seven-digit BCD
// mm:ss.mmm counter that saturates at MIN_MAX:59.999.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = 99
) (
   input  logic        clk,
   input  logic        rst,
   stopwatch_if.slave  bus
);

   localparam logic [MIN_W-1:0] MIN_MAX_BCD = to_bcd2(MIN_MAX);

   sw_state_t state;
   sw_state_t state_nxt;
   sw_cmd_t   cmd;
   sw_time_t  live;
   sw_time_t  lap_time;

   logic [DIGIT_W-1:0] ms0, ms1, ms2, s0, s1, m0, m1;
   logic ms1_inc, ms2_inc, s0_inc, s1_inc, m0_inc, m1_inc, m1_carry;
   logic counting, at_limit, cnt_inc, saturate, cnt_clear, lap_load;

   assign cmd      = pick_cmd(bus.cmd_clear, bus.cmd_startstop, bus.cmd_lap);
   assign live     = {m1, m0, s1, s0, ms2, ms1, ms0};
   assign at_limit = (live.min == MIN_MAX_BCD) && (live.sec == 8'h59) && (live.ms == 12'h999);
   assign counting = bus.ms_tick && ((state == ST_RUN) || (state == ST_LAP));
   assign cnt_inc  = counting && !at_limit;
   // A minute wrap cannot happen below the limit; treated as saturation as a guard.
   assign saturate = counting && (at_limit || m1_carry);

   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_ms0 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(cnt_inc), .value(ms0), .carry_out(ms1_inc));
   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_ms1 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(ms1_inc), .value(ms1), .carry_out(ms2_inc));
   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_ms2 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(ms2_inc), .value(ms2), .carry_out(s0_inc));
   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_s0 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(s0_inc), .value(s0), .carry_out(s1_inc));
   bcd_digit_cnt #(.MAX_VAL(TENS_SEC_MAX)) u_s1 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(s1_inc), .value(s1), .carry_out(m0_inc));
   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_m0 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(m0_inc), .value(m0), .carry_out(m1_inc));
   bcd_digit_cnt #(.MAX_VAL(DEC_MAX)) u_m1 (
      .clk(clk), .rst(rst), .clear(cnt_clear), .carry_in(m1_inc), .value(m1), .carry_out(m1_carry));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode plus counter clear and lap capture strobes.
   always_comb begin
      state_nxt = state;
      cnt_clear = 1'b0;
      lap_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd == CMD_STARTSTOP) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (saturate) begin
               state_nxt = ST_FULL;
            end else if (cmd == CMD_STARTSTOP) begin
               state_nxt = ST_PAUSE;
            end else if (cmd == CMD_LAP) begin
               state_nxt = ST_LAP;
               lap_load  = 1'b1;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_LAP: begin
            if (saturate) begin
               state_nxt = ST_FULL;
            end else if (cmd == CMD_STARTSTOP) begin
               state_nxt = ST_PAUSE;
            end else if (cmd == CMD_LAP) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_LAP;
            end
         end
         ST_PAUSE: begin
            if (cmd == CMD_CLEAR) begin
               state_nxt = ST_IDLE;
               cnt_clear = 1'b1;
            end else if (cmd == CMD_STARTSTOP) begin
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_PAUSE;
            end
         end
         ST_FULL: begin
            if (cmd == CMD_CLEAR) begin
               state_nxt = ST_IDLE;
               cnt_clear = 1'b1;
            end else begin
               state_nxt = ST_FULL;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   // Lap capture: snapshot of the live count taken on the edge entering LAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_time <= 28'h0000000;
      end else if (cnt_clear) begin
         lap_time <= 28'h0000000;
      end else if (lap_load) begin
         lap_time <= live;
      end
   end

   // Registered outputs: status flags track the state register, display lags the counter by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.run_en     <= 1'b0;
         bus.lap_active <= 1'b0;
         bus.full       <= 1'b0;
         bus.disp_min   <= 8'h00;
         bus.disp_sec   <= 8'h00;
         bus.disp_ms    <= 12'h000;
      end else begin
         bus.run_en     <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
         bus.lap_active <= (state_nxt == ST_LAP);
         bus.full       <= (state_nxt == ST_FULL);
         if (state == ST_LAP) begin
            bus.disp_min <= lap_time.min;
            bus.disp_sec <= lap_time.sec;
            bus.disp_ms  <= lap_time.ms;
         end else begin
            bus.disp_min <= live.min;
            bus.disp_sec <= live.sec;
            bus.disp_ms  <= live.ms;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one instance with the default minute
// limit and one with MIN_MAX=1 for the saturation case. Both see the same
// commands; long counts are shortened by forcing an inner carry net.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic cmd_startstop;
   logic cmd_lap;
   logic cmd_clear;
   logic ms_tick;

   int checks = 0;
   int errors = 0;

   stopwatch_if sw();
   stopwatch_if sw1();

   assign sw.cmd_startstop  = cmd_startstop;
   assign sw.cmd_lap        = cmd_lap;
   assign sw.cmd_clear      = cmd_clear;
   assign sw.ms_tick        = ms_tick;
   assign sw1.cmd_startstop = cmd_startstop;
   assign sw1.cmd_lap       = cmd_lap;
   assign sw1.cmd_clear     = cmd_clear;
   assign sw1.ms_tick       = ms_tick;

   stopwatch_ctrl #(.MIN_MAX(99)) dut  (.clk(clk), .rst(rst), .bus(sw.slave));
   stopwatch_ctrl #(.MIN_MAX(1))  dut1 (.clk(clk), .rst(rst), .bus(sw1.slave));

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag,
                             input logic [7:0] om, input logic [7:0] os, input logic [11:0] oms,
                             input logic [7:0] em, input logic [7:0] es, input logic [11:0] ems);
      check({tag, ".min"}, {24'h0, om}, {24'h0, em});
      check({tag, ".sec"}, {24'h0, os}, {24'h0, es});
      check({tag, ".ms"},  {20'h0, oms}, {20'h0, ems});
   endtask

   task automatic cmd_pulse(input logic ss, input logic lap, input logic clr);
      @(negedge clk);
      cmd_startstop = ss;
      cmd_lap       = lap;
      cmd_clear     = clr;
      @(negedge clk);
      cmd_startstop = 1'b0;
      cmd_lap       = 1'b0;
      cmd_clear     = 1'b0;
   endtask

   // Holds ms_tick high across exactly n rising edges.
   task automatic ticks(input int n);
      @(negedge clk);
      ms_tick = 1'b1;
      repeat (n) @(negedge clk);
      ms_tick = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      cmd_startstop = 1'b0;
      cmd_lap       = 1'b0;
      cmd_clear     = 1'b0;
      ms_tick       = 1'b0;
      #5;
      check("rst_run_en", {31'h0, sw.run_en}, 32'd0);
      check("rst_lap_active", {31'h0, sw.lap_active}, 32'd0);
      check("rst_full", {31'h0, sw.full}, 32'd0);
      check_time("rst_disp", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h000);
      @(negedge clk);
      rst = 1'b0;

      // Ticks in IDLE are ignored.
      ticks(5);
      settle();
      check_time("idle_ticks", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h000);
      check("idle_run_en", {31'h0, sw.run_en}, 32'd0);

      // Start and count 1234 ms.
      cmd_pulse(1'b1, 1'b0, 1'b0);
      check("start_run_en", {31'h0, sw.run_en}, 32'd1);
      ticks(1234);
      settle();
      check_time("run_1234", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h01, 12'h234);
      check("run_1234_run_en", {31'h0, sw.run_en}, 32'd1);

      // Asynchronous reset mid-RUN, between clock edges.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_run_en", {31'h0, sw.run_en}, 32'd0);
      check_time("async_rst_disp", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h000);
      @(negedge clk);
      rst = 1'b0;
      ticks(10);
      settle();
      check_time("post_rst_ticks", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h000);
      check("post_rst_run_en", {31'h0, sw.run_en}, 32'd0);
      cmd_pulse(1'b1, 1'b0, 1'b0);
      ticks(3);
      settle();
      check_time("post_rst_restart", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h003);

      // Lap freeze and release.
      do_reset();
      cmd_pulse(1'b1, 1'b0, 1'b0);
      ticks(2000);
      settle();
      check_time("run_2000", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h02, 12'h000);
      cmd_pulse(1'b0, 1'b1, 1'b0);
      check("lap_active_on", {31'h0, sw.lap_active}, 32'd1);
      check("lap_run_en", {31'h0, sw.run_en}, 32'd1);
      ticks(500);
      settle();
      check_time("lap_frozen", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h02, 12'h000);
      cmd_pulse(1'b0, 1'b1, 1'b0);
      settle();
      check_time("lap_release", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h02, 12'h500);
      check("lap_active_off", {31'h0, sw.lap_active}, 32'd0);

      // Pause ignores ticks; clear+startstop in PAUSE clears to IDLE.
      cmd_pulse(1'b1, 1'b0, 1'b0);
      check("pause_run_en", {31'h0, sw.run_en}, 32'd0);
      ticks(7);
      settle();
      check_time("pause_hold", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h02, 12'h500);
      cmd_pulse(1'b1, 1'b0, 1'b1);
      settle();
      check_time("clear_prio", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h000);
      check("clear_prio_run_en", {31'h0, sw.run_en}, 32'd0);
      cmd_pulse(1'b0, 1'b1, 1'b0);
      check("idle_lap_ignored", {31'h0, sw.lap_active}, 32'd0);
      cmd_pulse(1'b1, 1'b0, 1'b0);
      check("idle_to_run", {31'h0, sw.run_en}, 32'd1);
      ticks(4);
      settle();
      check_time("run_after_clear", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h00, 12'h004);
      // startstop beats lap in RUN: pause, no lap.
      cmd_pulse(1'b1, 1'b1, 1'b0);
      check("ss_over_lap_run_en", {31'h0, sw.run_en}, 32'd0);
      check("ss_over_lap_active", {31'h0, sw.lap_active}, 32'd0);

      // Full carry chain 00:59.999 -> 01:00.000.
      do_reset();
      cmd_pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      force dut.s0_inc = 1'b1;
      repeat (59) @(negedge clk);
      release dut.s0_inc;
      ticks(999);
      settle();
      check_time("pre_carry", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h59, 12'h999);
      ticks(1);
      check_time("carry_latency", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h00, 8'h59, 12'h999);
      settle();
      check_time("carry_done", sw.disp_min, sw.disp_sec, sw.disp_ms, 8'h01, 8'h00, 12'h000);

      // Saturation with MIN_MAX=1.
      do_reset();
      cmd_pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      force dut1.m0_inc = 1'b1;
      @(negedge clk);
      release dut1.m0_inc;
      force dut1.s0_inc = 1'b1;
      repeat (59) @(negedge clk);
      release dut1.s0_inc;
      ticks(999);
      settle();
      check_time("sat_pre", sw1.disp_min, sw1.disp_sec, sw1.disp_ms, 8'h01, 8'h59, 12'h999);
      check("sat_pre_full", {31'h0, sw1.full}, 32'd0);
      check("sat_pre_run_en", {31'h0, sw1.run_en}, 32'd1);
      ticks(1);
      settle();
      check("sat_full", {31'h0, sw1.full}, 32'd1);
      check("sat_run_en", {31'h0, sw1.run_en}, 32'd0);
      check_time("sat_held", sw1.disp_min, sw1.disp_sec, sw1.disp_ms, 8'h01, 8'h59, 12'h999);
      ticks(5);
      settle();
      check_time("sat_ticks_ignored", sw1.disp_min, sw1.disp_sec, sw1.disp_ms, 8'h01, 8'h59, 12'h999);
      cmd_pulse(1'b1, 1'b1, 1'b0);
      check("full_ss_ignored", {31'h0, sw1.full}, 32'd1);
      check("full_run_en", {31'h0, sw1.run_en}, 32'd0);
      check("full_lap_ignored", {31'h0, sw1.lap_active}, 32'd0);
      cmd_pulse(1'b0, 1'b0, 1'b1);
      settle();
      check_time("full_clear", sw1.disp_min, sw1.disp_sec, sw1.disp_ms, 8'h00, 8'h00, 12'h000);
      check("full_clear_full", {31'h0, sw1.full}, 32'd0);
      check("full_clear_run_en", {31'h0, sw1.run_en}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
